// File: rtl/easyaxi_rd_mst_q_pkg.sv
// Common widths, encodings and helpers for the queued AXI read master.
`include "easyaxi_define.v"

package easyaxi_rd_mst_q_pkg;

  localparam int ADDR_W  = `AXI_ADDR_W;
  localparam int DATA_W  = `AXI_DATA_W;
  localparam int ID_W    = `AXI_ID_W;
  localparam int LEN_W   = `AXI_LEN_W;
  localparam int SIZE_W  = `AXI_SIZE_W;
  localparam int BURST_W = `AXI_BURST_W;
  localparam int RESP_W  = `AXI_RESP_W;

  localparam logic [RESP_W-1:0] RESP_OKAY = `AXI_RESP_OKAY;

  // AR payload held by a slot until its request is accepted
  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } ar_t;

  // Index width for n entries, never below one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/easyaxi_define.v
// Shared AXI widths and encodings for the easyaxi blocks.
`ifndef EASYAXI_DEFINE_V
`define EASYAXI_DEFINE_V

`define AXI_ADDR_W  32
`define AXI_DATA_W  32
`define AXI_ID_W    4
`define AXI_LEN_W   8
`define AXI_SIZE_W  3
`define AXI_BURST_W 2
`define AXI_RESP_W  2

`define AXI_RESP_OKAY   2'b00
`define AXI_RESP_EXOKAY 2'b01
`define AXI_RESP_SLVERR 2'b10
`define AXI_RESP_DECERR 2'b11

`define AXI_BURST_FIXED 2'b00
`define AXI_BURST_INCR  2'b01
`define AXI_BURST_WRAP  2'b10

// Worst-of-two response; the encodings are ordered by severity.
`define AXI_RESP_MAX(a, b) (((a) > (b)) ? (a) : (b))

`endif

// File: rtl/easyaxi_rd_slot.sv
// One outstanding read: flags, AR payload, beat counter, worst response
// and the beat buffer the burst is replayed from on retire.
`include "easyaxi_define.v"

module easyaxi_rd_slot
  import easyaxi_rd_mst_q_pkg::*;
#(
  parameter int MAX_BURST_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc,
  input  logic [ADDR_W-1:0]    alloc_addr,
  input  logic [LEN_W-1:0]     alloc_len,
  input  logic [SIZE_W-1:0]    alloc_size,
  input  logic [BURST_W-1:0]   alloc_burst,
  input  logic                 ar_hs,
  input  logic                 beat_we,
  input  logic                 beat_last,
  input  logic [DATA_W-1:0]    rdata,
  input  logic [RESP_W-1:0]    rresp,
  input  logic                 free,
  input  logic [idx_w(MAX_BURST_LEN)-1:0] rd_idx,
  output logic                 valid,
  output logic                 ar_pend,
  output logic                 comp,
  output logic                 full,
  output logic [ADDR_W-1:0]    addr,
  output logic [LEN_W-1:0]     len,
  output logic [SIZE_W-1:0]    size,
  output logic [BURST_W-1:0]   burst,
  output logic [RESP_W-1:0]    resp,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_last
);

  localparam int IDX_W = idx_w(MAX_BURST_LEN);
  localparam int CNT_W = IDX_W + 1;

  logic              valid_q, ar_pend_q, comp_q;
  ar_t               pl_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [RESP_W-1:0] resp_q;
  logic [DATA_W-1:0] buf_q [MAX_BURST_LEN];

  // Slot lifecycle: allocate, AR accepted, beats counted, completed, freed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      ar_pend_q <= 1'b0;
      comp_q    <= 1'b0;
      pl_q      <= '0;
      cnt_q     <= '0;
      resp_q    <= RESP_OKAY;
    end else if (alloc) begin
      valid_q   <= 1'b1;
      ar_pend_q <= 1'b1;
      comp_q    <= 1'b0;
      pl_q      <= '{addr: alloc_addr, len: alloc_len, size: alloc_size, burst: alloc_burst};
      cnt_q     <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      if (ar_hs)
        ar_pend_q <= 1'b0;
      if (beat_we) begin
        cnt_q  <= cnt_q + 1'b1;
        resp_q <= `AXI_RESP_MAX(resp_q, rresp);
      end
      if (beat_last)
        comp_q <= 1'b1;
      if (free) begin
        valid_q <= 1'b0;
        comp_q  <= 1'b0;
      end
    end
  end

  // Beat data lands at the current count position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_BURST_LEN; i++)
        buf_q[i] <= '0;
    end else if (beat_we) begin
      buf_q[cnt_q[IDX_W-1:0]] <= rdata;
    end
  end

  assign valid   = valid_q;
  assign ar_pend = ar_pend_q;
  assign comp    = comp_q;
  assign addr    = pl_q.addr;
  assign len     = pl_q.len;
  assign size    = pl_q.size;
  assign burst   = pl_q.burst;
  assign resp    = resp_q;
  assign full    = (cnt_q == ({1'b0, pl_q.len[IDX_W-1:0]} + 1'b1));
  // Beats never received (early rlast) read back as zero
  assign rd_data = ({1'b0, rd_idx} < cnt_q) ? buf_q[rd_idx] : '0;
  assign rd_last = comp_q & (rd_idx == pl_q.len[IDX_W-1:0]);

endmodule

// File: rtl/easyaxi_rd_mst_q.sv
// Command-driven AXI read master: in-order AR issue, out-of-order R capture
// by slot ID, in-order retire of whole bursts as a beat stream.
`include "easyaxi_define.v"

module easyaxi_rd_mst_q
  import easyaxi_rd_mst_q_pkg::*;
#(
  parameter int OST_DEPTH     = 4,
  parameter int MAX_BURST_LEN = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [SIZE_W-1:0]  cmd_size,
  input  logic [BURST_W-1:0] cmd_burst,
  output logic               axi_mst_arvalid,
  input  logic               axi_mst_arready,
  output logic [ID_W-1:0]    axi_mst_arid,
  output logic [ADDR_W-1:0]  axi_mst_araddr,
  output logic [LEN_W-1:0]   axi_mst_arlen,
  output logic [SIZE_W-1:0]  axi_mst_arsize,
  output logic [BURST_W-1:0] axi_mst_arburst,
  input  logic               axi_mst_rvalid,
  output logic               axi_mst_rready,
  input  logic [ID_W-1:0]    axi_mst_rid,
  input  logic [DATA_W-1:0]  axi_mst_rdata,
  input  logic [RESP_W-1:0]  axi_mst_rresp,
  input  logic               axi_mst_rlast,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ID_W-1:0]    res_id,
  output logic [DATA_W-1:0]  res_data,
  output logic [RESP_W-1:0]  res_resp,
  output logic               res_last,
  output logic               err_cmd,
  output logic               err_rid,
  output logic               err_ovf,
  output logic               idle
);

  localparam int SLOT_W = idx_w(OST_DEPTH);
  localparam int IDX_W  = idx_w(MAX_BURST_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST_LEN);

  logic [SLOT_W-1:0] set_ptr, req_ptr, ret_ptr;
  logic [IDX_W-1:0]  ret_beat;

  logic [OST_DEPTH-1:0] valid_v, ar_pend_v, comp_v, full_v, last_v;
  logic [ADDR_W-1:0]    addr_a  [OST_DEPTH];
  logic [LEN_W-1:0]     len_a   [OST_DEPTH];
  logic [SIZE_W-1:0]    size_a  [OST_DEPTH];
  logic [BURST_W-1:0]   burst_a [OST_DEPTH];
  logic [RESP_W-1:0]    resp_a  [OST_DEPTH];
  logic [DATA_W-1:0]    data_a  [OST_DEPTH];

  logic              cmd_hs, cmd_bad, do_alloc, ar_hs, res_hs, res_done;
  logic              rid_ok, r_ok, r_hit, r_we, r_ovf;
  logic [SLOT_W-1:0] r_slot;

  function automatic logic [SLOT_W-1:0] ptr_inc(input logic [SLOT_W-1:0] p);
    return (p == SLOT_W'(OST_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cmd_hs   = cmd_valid & cmd_ready;
  // Over-long commands are consumed so the source never stalls on them
  assign cmd_bad  = (cmd_len >= MAX_LEN);
  assign do_alloc = cmd_hs & ~cmd_bad;
  assign ar_hs    = axi_mst_arvalid & axi_mst_arready;
  assign res_hs   = res_valid & res_ready;
  assign res_done = res_hs & res_last;

  assign rid_ok = ({1'b0, axi_mst_rid} < (ID_W + 1)'(OST_DEPTH));
  assign r_slot = axi_mst_rid[SLOT_W-1:0];
  assign r_ok   = rid_ok & valid_v[r_slot] & ~ar_pend_v[r_slot] & ~comp_v[r_slot];
  assign r_hit  = axi_mst_rvalid & r_ok;
  assign r_we   = r_hit & ~full_v[r_slot];
  assign r_ovf  = r_hit & full_v[r_slot];

  for (genvar g = 0; g < OST_DEPTH; g++) begin : g_slot
    easyaxi_rd_slot #(
      .MAX_BURST_LEN(MAX_BURST_LEN)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .alloc      (do_alloc && (set_ptr == SLOT_W'(g))),
      .alloc_addr (cmd_addr),
      .alloc_len  (cmd_len),
      .alloc_size (cmd_size),
      .alloc_burst(cmd_burst),
      .ar_hs      (ar_hs && (req_ptr == SLOT_W'(g))),
      .beat_we    (r_we && (r_slot == SLOT_W'(g))),
      // An overflow beat still closes the burst so a misbehaving slave cannot wedge the queue
      .beat_last  (r_hit && axi_mst_rlast && (r_slot == SLOT_W'(g))),
      .rdata      (axi_mst_rdata),
      .rresp      (axi_mst_rresp),
      .free       (res_done && (ret_ptr == SLOT_W'(g))),
      .rd_idx     (ret_beat),
      .valid      (valid_v[g]),
      .ar_pend    (ar_pend_v[g]),
      .comp       (comp_v[g]),
      .full       (full_v[g]),
      .addr       (addr_a[g]),
      .len        (len_a[g]),
      .size       (size_a[g]),
      .burst      (burst_a[g]),
      .resp       (resp_a[g]),
      .rd_data    (data_a[g]),
      .rd_last    (last_v[g])
    );
  end

  // Circular pointers for allocate, request and retire, plus the retire beat index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_ptr  <= '0;
      req_ptr  <= '0;
      ret_ptr  <= '0;
      ret_beat <= '0;
    end else begin
      if (do_alloc)
        set_ptr <= ptr_inc(set_ptr);
      if (ar_hs)
        req_ptr <= ptr_inc(req_ptr);
      if (res_hs) begin
        if (res_last) begin
          ret_ptr  <= ptr_inc(ret_ptr);
          ret_beat <= '0;
        end else begin
          ret_beat <= ret_beat + 1'b1;
        end
      end
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cmd <= 1'b0;
      err_rid <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      if (cmd_hs && cmd_bad)
        err_cmd <= 1'b1;
      if (axi_mst_rvalid && !r_ok)
        err_rid <= 1'b1;
      if (r_ovf)
        err_ovf <= 1'b1;
    end
  end

  assign cmd_ready       = ~valid_v[set_ptr];
  assign axi_mst_arvalid = ar_pend_v[req_ptr];
  assign axi_mst_arid    = ID_W'(req_ptr);
  assign axi_mst_araddr  = addr_a[req_ptr];
  assign axi_mst_arlen   = len_a[req_ptr];
  assign axi_mst_arsize  = size_a[req_ptr];
  assign axi_mst_arburst = burst_a[req_ptr];
  // Every slot reserves a full buffer, so R is never back-pressured
  assign axi_mst_rready  = 1'b1;
  assign res_valid       = comp_v[ret_ptr];
  assign res_id          = ID_W'(ret_ptr);
  assign res_data        = data_a[ret_ptr];
  assign res_resp        = resp_a[ret_ptr];
  assign res_last        = last_v[ret_ptr];
  assign idle            = ~|valid_v;

endmodule

// File: tb/tb_easyaxi_rd_mst_q.sv
// Directed bench for easyaxi_rd_mst_q with OST_DEPTH=4, MAX_BURST_LEN=8.
module tb_easyaxi_rd_mst_q;
  import easyaxi_rd_mst_q_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cmd_valid, cmd_ready;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [LEN_W-1:0]   cmd_len;
  logic [SIZE_W-1:0]  cmd_size;
  logic [BURST_W-1:0] cmd_burst;
  logic               arvalid, arready;
  logic [ID_W-1:0]    arid;
  logic [ADDR_W-1:0]  araddr;
  logic [LEN_W-1:0]   arlen;
  logic [SIZE_W-1:0]  arsize;
  logic [BURST_W-1:0] arburst;
  logic               rvalid, rready, rlast;
  logic [ID_W-1:0]    rid;
  logic [DATA_W-1:0]  rdata;
  logic [RESP_W-1:0]  rresp;
  logic               res_valid, res_ready, res_last;
  logic [ID_W-1:0]    res_id;
  logic [DATA_W-1:0]  res_data;
  logic [RESP_W-1:0]  res_resp;
  logic               err_cmd, err_rid, err_ovf, idle;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  easyaxi_rd_mst_q #(.OST_DEPTH(4), .MAX_BURST_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .axi_mst_arvalid(arvalid), .axi_mst_arready(arready), .axi_mst_arid(arid),
    .axi_mst_araddr(araddr), .axi_mst_arlen(arlen), .axi_mst_arsize(arsize),
    .axi_mst_arburst(arburst),
    .axi_mst_rvalid(rvalid), .axi_mst_rready(rready), .axi_mst_rid(rid),
    .axi_mst_rdata(rdata), .axi_mst_rresp(rresp), .axi_mst_rlast(rlast),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_data(res_data), .res_resp(res_resp), .res_last(res_last),
    .err_cmd(err_cmd), .err_rid(err_rid), .err_ovf(err_ovf), .idle(idle)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    arready = 1'b0;
    rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
    res_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    #2;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [7:0] len);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len; cmd_size = 3'd2; cmd_burst = 2'b01;
    for (int w = 0; w < 20 && !cmd_ready; w++) tick();
    chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] d, input logic [1:0] rs, input logic l);
    rvalid = 1'b1; rid = id; rdata = d; rresp = rs; rlast = l;
    tick();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic r_burst(input logic [3:0] id, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) r_beat(id, base + 32'(k), 2'b00, (k == n - 1));
  endtask

  task automatic collect(input string tag, input int id, input logic [31:0] base,
                         input int n, input int nvalid, input logic [1:0] resp);
    res_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      for (int w = 0; w < 30 && !res_valid; w++) tick();
      chk({tag, "_valid"}, 64'(res_valid), 64'(1));
      chk({tag, "_id"},    64'(res_id),    64'(id));
      chk({tag, "_data"},  64'(res_data),  64'((k < nvalid) ? base + 32'(k) : 32'd0));
      chk({tag, "_resp"},  64'(res_resp),  64'(resp));
      chk({tag, "_last"},  64'(res_last),  64'(k == n - 1));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    rst_n = 1'b0;
    clear_inputs();
    #12;
    chk("rst_arvalid",   64'(arvalid),   64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_errs",      64'({err_cmd, err_rid, err_ovf}), 64'(0));
    chk("rst_idle",      64'(idle),      64'(1));
    chk("rst_rready",    64'(rready),    64'(1));
    chk("rst_araddr",    64'(araddr),    64'(0));
    chk("rst_arid",      64'(arid),      64'(0));
    chk("rst_res_data",  64'(res_data),  64'(0));
    chk("rst_res_last",  64'(res_last),  64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    tick();
    rst_n = 1'b1;
    tick();

    // single burst, 4 beats
    arready = 1'b1;
    send_cmd(32'h40, 8'd3);
    chk("t1_arvalid", 64'(arvalid), 64'(1));
    chk("t1_arid",    64'(arid),    64'(0));
    chk("t1_araddr",  64'(araddr),  64'(32'h40));
    chk("t1_arlen",   64'(arlen),   64'(3));
    chk("t1_arsize",  64'(arsize),  64'(2));
    chk("t1_arburst", 64'(arburst), 64'(1));
    chk("t1_busy",    64'(idle),    64'(0));
    tick();
    chk("t1_ar_once", 64'(arvalid), 64'(0));
    r_burst(4'd0, 32'hA0, 4);
    chk("t1_res_lat", 64'(res_valid), 64'(1));
    collect("t1", 0, 32'hA0, 4, 4, 2'b00);
    chk("t1_idle", 64'(idle), 64'(1));

    // four outstanding, R returned 3,1,0,2, retired 0,1,2,3
    do_reset();
    arready = 1'b1;
    send_cmd(32'h100, 8'd1);
    send_cmd(32'h200, 8'd1);
    send_cmd(32'h300, 8'd1);
    send_cmd(32'h400, 8'd1);
    chk("t2_full", 64'(cmd_ready), 64'(0));
    tick();
    tick();
    chk("t2_ar_done", 64'(arvalid), 64'(0));
    r_burst(4'd3, 32'hF0, 2);
    r_burst(4'd1, 32'hD0, 2);
    chk("t2_no_res", 64'(res_valid), 64'(0));
    r_burst(4'd0, 32'hC0, 2);
    chk("t2_res0", 64'(res_valid), 64'(1));
    r_burst(4'd2, 32'hE0, 2);
    chk("t2_still_full", 64'(cmd_ready), 64'(0));
    collect("t2_id0", 0, 32'hC0, 2, 2, 2'b00);
    chk("t2_freed", 64'(cmd_ready), 64'(1));
    collect("t2_id1", 1, 32'hD0, 2, 2, 2'b00);
    collect("t2_id2", 2, 32'hE0, 2, 2, 2'b00);
    collect("t2_id3", 3, 32'hF0, 2, 2, 2'b00);
    chk("t2_idle", 64'(idle), 64'(1));
    chk("t2_no_err", 64'({err_cmd, err_rid, err_ovf}), 64'(0));

    // AR stall: payload stable, single issue; then worst-resp merge
    do_reset();
    send_cmd(32'h1000, 8'd2);
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_valid", 64'(arvalid), 64'(1));
      chk("t3_hold_addr",  64'(araddr),  64'(32'h1000));
      chk("t3_hold_len",   64'(arlen),   64'(2));
      tick();
    end
    arready = 1'b1;
    tick();
    chk("t3_ar_taken", 64'(arvalid), 64'(0));
    tick();
    chk("t3_no_dup", 64'(arvalid), 64'(0));
    r_beat(4'd0, 32'hD0, 2'b00, 1'b0);
    r_beat(4'd0, 32'hD1, 2'b10, 1'b0);
    r_beat(4'd0, 32'hD2, 2'b00, 1'b1);
    collect("t4_slverr", 0, 32'hD0, 3, 3, 2'b10);

    // illegal length dropped; next legal (longest) command gets ID 0
    do_reset();
    arready = 1'b1;
    send_cmd(32'h2000, 8'd8);
    chk("t5_err_cmd", 64'(err_cmd),   64'(1));
    chk("t5_no_ar",   64'(arvalid),   64'(0));
    chk("t5_idle",    64'(idle),      64'(1));
    send_cmd(32'h3000, 8'd7);
    chk("t5_arvalid", 64'(arvalid), 64'(1));
    chk("t5_arid",    64'(arid),    64'(0));
    chk("t5_araddr",  64'(araddr),  64'(32'h3000));
    chk("t5_arlen",   64'(arlen),   64'(7));
    tick();
    r_burst(4'd0, 32'h50, 8);
    collect("t5_len7", 0, 32'h50, 8, 8, 2'b00);

    // bad RID, then overflow beat carrying rlast
    do_reset();
    arready = 1'b1;
    chk("t6_err_clr", 64'(err_cmd), 64'(0));
    send_cmd(32'h4000, 8'd3);
    tick();
    r_beat(4'd5, 32'h55, 2'b00, 1'b1);
    chk("t6_err_rid", 64'(err_rid),   64'(1));
    chk("t6_no_ovf",  64'(err_ovf),   64'(0));
    chk("t6_no_res",  64'(res_valid), 64'(0));
    for (int k = 0; k < 4; k++) r_beat(4'd0, 32'hE0 + 32'(k), 2'b00, 1'b0);
    chk("t6_wait_last", 64'(res_valid), 64'(0));
    r_beat(4'd0, 32'hEE, 2'b00, 1'b1);
    chk("t6_err_ovf", 64'(err_ovf),   64'(1));
    chk("t6_res",     64'(res_valid), 64'(1));
    collect("t6_ovf", 0, 32'hE0, 4, 4, 2'b00);

    // early rlast: missing beats read as zero
    send_cmd(32'h5000, 8'd3);
    chk("t7_arid", 64'(arid), 64'(1));
    tick();
    r_beat(4'd1, 32'hF0, 2'b00, 1'b0);
    r_beat(4'd1, 32'hF1, 2'b01, 1'b1);
    collect("t7_early", 1, 32'hF0, 4, 2, 2'b01);
    chk("t7_sticky", 64'({err_rid, err_ovf}), 64'(3));

    // reset mid-burst discards everything
    send_cmd(32'h6000, 8'd3);
    tick();
    r_beat(4'd2, 32'h11, 2'b00, 1'b0);
    do_reset();
    chk("t8_idle",    64'(idle),      64'(1));
    chk("t8_arvalid", 64'(arvalid),   64'(0));
    chk("t8_res",     64'(res_valid), 64'(0));
    chk("t8_arid",    64'(arid),      64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/easyaxi_rd_mst_q.md
# easyaxi_rd_mst_q

Parametrised, command-driven AXI read master with a configurable outstanding depth and burst length. Accepts read commands on a valid/ready command port, issues AR requests in order, and accepts R beats out of order across IDs. Completed bursts retire to a beat-stream result port in command order. Sits between a traffic source (test sequencer or DMA front end) and an AXI slave/interconnect.

## Interface
Parameters:
- OST_DEPTH, 4: outstanding slots; power of 2, 1..16.
- MAX_BURST_LEN, 8: maximum beats per burst; power of 2, 1..16.
- AXI widths come from the shared `AXI_*_W` defines. ID_W equals `AXI_ID_W` and must be >= clog2(OST_DEPTH).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- cmd_addr, cmd_len, cmd_size, cmd_burst  in  `AXI_ADDR_W`/`AXI_LEN_W`/`AXI_SIZE_W`/`AXI_BURST_W`  AR payload.
- axi_mst_ar*  out  AR channel: arvalid, arid, araddr, arlen, arsize, arburst; arready is an input.
- axi_mst_r*  in  R channel: rvalid, rid, rdata, rresp, rlast; rready is an output.
- res_valid / res_ready  out / in  1  result-beat handshake.
- res_id  out  `AXI_ID_W`  slot ID of the retiring burst.
- res_data  out  `AXI_DATA_W`  beat data.
- res_resp  out  `AXI_RESP_W`  worst response of the whole burst.
- res_last  out  1  final beat of the burst.
- err_cmd, err_rid, err_ovf  out  1  sticky errors: illegal length, unexpected RID, beat overflow.
- idle  out  1  high when no slot is valid.

## Operation
- Each slot holds: valid, ar_pend, comp, addr, len, size, burst, beat count, worst resp, and a data buffer of MAX_BURST_LEN × `AXI_DATA_W`.
- Slot ID equals the slot index, zero-extended to ID_W.
- Three circular pointers:
  - set_ptr advances on allocate.
  - req_ptr advances on AR handshake.
  - ret_ptr advances on result-beat handshake with res_last high.
  - All three wrap from OST_DEPTH-1 to 0.
- cmd_ready = ~valid[set_ptr].
- A command with cmd_len >= MAX_BURST_LEN is still handshaken, but it is dropped: no slot is allocated, err_cmd is set, and set_ptr holds.
- Allocate sets valid and ar_pend, clears comp, zeroes the beat count and sets resp to OKAY.
- AR channel:
  - arvalid = ar_pend[req_ptr]; payload is driven from slot[req_ptr].
  - On handshake, ar_pend clears.
- R channel:
  - rready = 1 constantly, because buffer space is reserved per slot.
  - A beat for rid is captured only if rid < OST_DEPTH, valid[rid] = 1, ar_pend[rid] = 0 and comp[rid] = 0. Otherwise the beat is dropped and err_rid is set.
  - On capture: data is written at index beat count, the count increments, and resp is updated to the maximum of stored and rresp.
  - rlast sets comp.
  - A beat arriving when count = len+1 is dropped, and err_ovf is set.
  - If rlast arrives before len+1 beats, the burst completes with the beats received; remaining beats read back as 0.
- Retire: when comp[ret_ptr] = 1, stream beats 0..len of that slot.
  - res_last is high on beat len.
  - Final handshake clears valid and comp.
- Error flags clear only on reset.

## Timing
- Reset values:
  - Outputs: arvalid, res_valid and all err_* = 0; idle = 1; rready = 1; all payload outputs = 0.
  - State: pointers and all slot state = 0.
- Latency:
  - Command handshake to arvalid: 1 cycle.
  - Captured rlast to res_valid: 1 cycle.
  - Result beats stream at 1 per cycle while res_ready is high.
- AR payload is stable while arvalid is high without arready. res_* are stable while res_valid is high without res_ready.
- Same-cycle allocate and retire of different slots are both permitted. A slot freed in cycle N can be reallocated in cycle N+1.
- R capture and AR issue for different slots in the same cycle are independent.
- Asynchronous reset mid-burst discards all slots and results. No AR is reissued.

## Structure
- Shared define file easyaxi_define.v supplies `AXI_*_W`, `AXI_RESP_*` and `AXI_BURST_*`. Add `AXI_RESP_MAX` there; do not define it locally.
- Sub-module easyaxi_rd_slot holds one slot's flags, payload, beat counter, resp merge and data buffer. It is instantiated OST_DEPTH times from a generate loop.
- Pointer control, AR/result muxing and error flags live in the top level.

## Test plan
- One command, addr=0x40, len=3, size=4B, INCR, with arready and res_ready always high → AR issued 1 cycle after the command; 4 beats 0xA0..0xA3 retire in order; res_last on 0xA3; res_resp=OKAY; idle=1 afterwards.
- Four commands (IDs 0..3), then R bursts returned in ID order 3,1,0,2 → results are ID 0,1,2,3 in that order; cmd_ready=0 until ID 0 retires.
- arready held low for 5 cycles → araddr/arlen stable; no duplicate AR.
- Burst whose beat 1 has rresp=SLVERR and beat 2 has OKAY → res_resp=SLVERR on all beats.
- cmd_len=MAX_BURST_LEN → err_cmd=1, no AR; a following legal command gets ID 0.
- rid=5 with OST_DEPTH=4, then a 5th beat on a len=3 burst → err_rid=1, then err_ovf=1; the valid burst still retires 4 correct beats.
